// File: rtl/image_stream_3ch_tx.sv
// rtl/image_stream_3ch_tx.sv - streams a stored 3-channel image, zero-padded, into a convolution input
// Raster scan over the padded frame; interior pixels read memory, border pixels emit zeros.
module image_stream_3ch_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56,
  parameter int PAD        = 1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_0,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_1,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_2,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  data_valid_out,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W = IMG_WIDTH + 2 * PAD;
  localparam int OUT_H = IMG_HEIGHT + 2 * PAD;
  localparam int CW    = $clog2(OUT_W + 1);
  localparam int RW    = $clog2(OUT_H + 1);

  localparam logic [CW-1:0] COL_LO   = CW'(PAD);
  localparam logic [CW-1:0] COL_HI   = CW'(OUT_W - PAD);
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_LO   = RW'(PAD);
  localparam logic [RW-1:0] ROW_HI   = RW'(OUT_H - PAD);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH-1:0] addr_last;
  logic                  accept;
  logic                  issue;
  logic                  interior;
  logic                  last_pix;
  logic                  iss_valid;
  logic                  iss_interior;

  // busy is registered, so it still reads high in the cycle after DONE; gating on it
  // makes a start coinciding with the done pulse fall on the floor.
  assign accept   = (state == IDLE) && start && !busy;
  assign issue    = (state == STREAM) && !stall;
  assign interior = (row >= ROW_LO) && (row < ROW_HI) && (col >= COL_LO) && (col < COL_HI);
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  assign mem_rd_en = issue && interior;
  assign mem_addr  = mem_rd_en ? addr_cnt : addr_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = STREAM;
      STREAM:  if (issue && last_pix) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Linear address advances only on reads, which keeps it equal to row*IMG_WIDTH+col
  // of the unpadded image without a multiplier.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row       <= '0;
      col       <= '0;
      addr_cnt  <= '0;
      addr_last <= '0;
    end else if (accept) begin
      row      <= '0;
      col      <= '0;
      addr_cnt <= '0;
    end else if (issue) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
      if (interior) begin
        addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
        addr_last <= addr_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iss_valid    <= 1'b0;
      iss_interior <= 1'b0;
    end else begin
      iss_valid <= issue;
      if (issue) begin
        iss_interior <= interior;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out_0     <= '0;
      data_out_1     <= '0;
      data_out_2     <= '0;
      data_valid_out <= 1'b0;
    end else if (iss_valid) begin
      data_valid_out <= 1'b1;
      if (iss_interior) begin
        data_out_0 <= mem_rd_data_0;
        data_out_1 <= mem_rd_data_1;
        data_out_2 <= mem_rd_data_2;
      end else begin
        data_out_0 <= '0;
        data_out_1 <= '0;
        data_out_2 <= '0;
      end
    end else begin
      data_valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_image_stream_3ch_tx.sv
// tb/tb_image_stream_3ch_tx.sv - self-checking bench for image_stream_3ch_tx
`timescale 1ns/1ps
module tb_image_stream_3ch_tx;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int IW = 3;
  localparam int IH = 2;
  localparam int OW = IW + 2;
  localparam int OH = IH + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, start, stall, start0;
  logic          mem_rd_en, data_valid_out, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] rd_0, rd_1, rd_2, data_out_0, data_out_1, data_out_2;

  logic          mem_rd_en0, data_valid_out0, busy0, done0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] rd0_0, rd0_1, rd0_2, d0_0, d0_1, d0_2;

  image_stream_3ch_tx #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .PAD(1), .ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .stall(stall),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data_0(rd_0), .mem_rd_data_1(rd_1), .mem_rd_data_2(rd_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_valid_out(data_valid_out), .busy(busy), .done(done)
  );

  image_stream_3ch_tx #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .PAD(0), .ADDR_WIDTH(AW)) u_dut0 (
    .clk(clk), .resetn(resetn), .start(start0), .stall(1'b0),
    .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0),
    .mem_rd_data_0(rd0_0), .mem_rd_data_1(rd0_1), .mem_rd_data_2(rd0_2),
    .data_out_0(d0_0), .data_out_1(d0_1), .data_out_2(d0_2),
    .data_valid_out(data_valid_out0), .busy(busy0), .done(done0)
  );

  // Memory: channel n at address a holds 100*n + a, one cycle read latency.
  initial begin
    rd_0 = '0; rd_1 = '0; rd_2 = '0; rd0_0 = '0; rd0_1 = '0; rd0_2 = '0;
  end
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd_0 <= 32'(mem_addr); rd_1 <= 32'(mem_addr) + 100; rd_2 <= 32'(mem_addr) + 200;
    end
    if (mem_rd_en0) begin
      rd0_0 <= 32'(mem_addr0); rd0_1 <= 32'(mem_addr0) + 100; rd0_2 <= 32'(mem_addr0) + 200;
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed { logic [31:0] c0, c1, c2; } pix_t;
  pix_t exp_q[$];

  int vcnt, rdcnt, done_cnt, done_cyc, busy_first, busy_last, exp_addr;
  bit busy_seen;
  int vcyc[64];
  logic [31:0] g0[64], g1[64], g2[64];
  logic [31:0] l0 = 0, l1 = 0, l2 = 0;

  // Expected padded frame computed directly from geometry.
  task automatic clear_stats();
    pix_t p;
    vcnt = 0; rdcnt = 0; done_cnt = 0; done_cyc = -1;
    busy_first = -1; busy_last = -1; busy_seen = 0; exp_addr = 0;
    exp_q.delete();
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        if (r >= 1 && r < OH - 1 && c >= 1 && c < OW - 1) begin
          p.c0 = 32'((r - 1) * IW + (c - 1));
          p.c1 = p.c0 + 100;
          p.c2 = p.c0 + 200;
        end else begin
          p = '0;
        end
        exp_q.push_back(p);
      end
    end
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (!resetn) begin
      l0 = 0; l1 = 0; l2 = 0;
    end else begin
      if (busy) begin
        if (!busy_seen) busy_first = cyc;
        busy_seen = 1;
        busy_last = cyc;
      end
      if (data_valid_out) begin
        if (vcnt < 64) begin
          vcyc[vcnt] = cyc; g0[vcnt] = data_out_0; g1[vcnt] = data_out_1; g2[vcnt] = data_out_2;
        end
        vcnt++;
        if (exp_q.size() == 0) begin
          check("extra_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix_ch0", int'(data_out_0), int'(e.c0));
          check("pix_ch1", int'(data_out_1), int'(e.c1));
          check("pix_ch2", int'(data_out_2), int'(e.c2));
        end
        l0 = data_out_0; l1 = data_out_1; l2 = data_out_2;
      end else begin
        check("hold_ch0", int'(data_out_0), int'(l0));
        check("hold_ch1", int'(data_out_1), int'(l1));
        check("hold_ch2", int'(data_out_2), int'(l2));
      end
      if (mem_rd_en) begin
        check("rd_addr", int'(mem_addr), exp_addr);
        exp_addr++;
        rdcnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_no_valid", int'(data_valid_out), 0);
      end
    end
  end

  int v0cnt, rd0cnt, done0_cnt, done0_cyc, first0;
  always @(negedge clk) begin
    if (resetn) begin
      if (data_valid_out0) begin
        if (v0cnt == 0) first0 = cyc;
        check("pad0_ch0", int'(d0_0), v0cnt);
        check("pad0_ch1", int'(d0_1), v0cnt + 100);
        check("pad0_ch2", int'(d0_2), v0cnt + 200);
        v0cnt++;
      end
      if (mem_rd_en0) rd0cnt++;
      if (done0) begin
        done0_cnt++;
        done0_cyc = cyc;
      end
    end
  end

  task automatic pulse_start(output int k);
    @(posedge clk); #1 start = 1'b1; k = cyc + 1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int k, input int extra);
    check("busy_first", busy_first, k + 1);
    check("first_valid", vcyc[0], k + 2);
    check("valid_count", vcnt, OW * OH);
    check("last_valid", vcyc[OW * OH - 1], k + 21 + extra);
    check("done_cycle", done_cyc, k + 22 + extra);
    check("done_count", done_cnt, 1);
    check("busy_last", busy_last, k + 22 + extra);
    check("read_count", rdcnt, IW * IH);
    check("model_drained", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, int'(mem_rd_en), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
    check({tag, "_dv"}, int'(data_valid_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_d0"}, int'(data_out_0), 0);
    check({tag, "_d1"}, int'(data_out_1), 0);
    check({tag, "_d2"}, int'(data_out_2), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k, nz, ngaps, gaplen;
    resetn = 1'b0; start = 1'b0; stall = 1'b0; start0 = 1'b0;
    v0cnt = 0; rd0cnt = 0; done0_cnt = 0; done0_cyc = -1; first0 = -1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Plain frame, plus literal pins on the model.
    clear_stats();
    pulse_start(k);
    wait_done(60);
    check_frame(k, 0);
    check("pin_r1c1_ch0", int'(g0[6]), 0);
    check("pin_r1c1_ch1", int'(g1[6]), 100);
    check("pin_r1c1_ch2", int'(g2[6]), 200);
    check("pin_r2c3_ch0", int'(g0[13]), 5);
    check("pin_r2c3_ch1", int'(g1[13]), 105);
    check("pin_r2c3_ch2", int'(g2[13]), 205);
    nz = 0;
    for (int i = 0; i < OW * OH; i++) if (g0[i] == 0 && g1[i] == 0 && g2[i] == 0) nz++;
    check("border_zero_count", nz, 14);

    // Three stall cycles mid-row.
    clear_stats();
    pulse_start(k);
    repeat (4) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done(60);
    check_frame(k, 3);
    ngaps = 0; gaplen = 0;
    for (int i = 1; i < OW * OH; i++) begin
      if (vcyc[i] - vcyc[i-1] != 1) begin
        ngaps++;
        gaplen = vcyc[i] - vcyc[i-1] - 1;
      end
    end
    check("stall_gap_count", ngaps, 1);
    check("stall_gap_len", gaplen, 3);
    check("stall_gap_pos", vcyc[4], k + 9);

    // Reset mid-frame aborts without done.
    clear_stats();
    pulse_start(k);
    repeat (8) @(posedge clk);
    #1 resetn = 1'b0;
    #1 check_idle_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", int'(busy), 0);
    clear_stats();
    pulse_start(k);
    wait_done(60);
    check_frame(k, 0);

    // start during STREAM and during the done cycle are ignored.
    clear_stats();
    pulse_start(k);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1 check("done_at_late_start", int'(done), 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check_frame(k, 0);
    check("ignored_start_idle", int'(busy), 0);

    // Unpadded instance.
    @(posedge clk); #1 start0 = 1'b1; k = cyc + 1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int i = 0; i < 40 && done0_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("pad0_valid_count", v0cnt, IW * IH);
    check("pad0_read_count", rd0cnt, IW * IH);
    check("pad0_first_valid", first0, k + 2);
    check("pad0_done_cycle", done0_cyc, k + 8);
    check("pad0_done_count", done0_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/image_stream_3ch_tx.md
IMAGE_STREAM_3CH_TX -- requirements
Module: image_stream_3ch_tx

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of one channel sample.
REQ-002 Parameter IMG_WIDTH, 56, image columns stored in memory.
REQ-003 Parameter IMG_HEIGHT, 56, image rows stored in memory.
REQ-004 Parameter PAD, 1, zero-border width added on every side (0 or 1).
REQ-005 Parameter ADDR_WIDTH, 12, memory address width; SHALL satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT.
REQ-006 One clock and one reset: reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 resetn  in  1  asynchronous active-low reset.
REQ-009 start  in  1  single-cycle request to stream one frame.
REQ-010 stall  in  1  while high, no new pixel is issued.
REQ-011 mem_rd_en  out  1  memory read strobe.
REQ-012 mem_addr  out  ADDR_WIDTH  linear pixel address, row-major, row*IMG_WIDTH+col.
REQ-013 mem_rd_data_0/1/2  in  DATA_WIDTH each  channel 0/1/2 read data, valid exactly one cycle after mem_rd_en.
REQ-014 data_out_0/1/2  out  DATA_WIDTH each  channel 0/1/2 pixel to the 3-channel convolution input.
REQ-015 data_valid_out  out  1  pixel-valid strobe, drives the convolution data_valid_in.
REQ-016 busy  out  1  high from start acceptance until done pulse inclusive.
REQ-017 done  out  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-018 Output frame SHALL be OUT_W=IMG_WIDTH+2*PAD by OUT_H=IMG_HEIGHT+2*PAD pixels, raster order, column fastest.
REQ-019 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-020 IDLE: start=1 -> STREAM; row, col, addr counters cleared to 0.
REQ-021 STREAM, stall=0: issue pixel (row,col); col wraps at OUT_W-1 to 0 and increments row.
REQ-022 Interior pixel (PAD<=row<OUT_H-PAD and PAD<=col<OUT_W-PAD): mem_rd_en=1, mem_addr=addr counter, addr increments by 1 after issue; no multiplier used.
REQ-023 Border pixel: mem_rd_en=0, mem_addr holds previous value.
REQ-024 Every issued pixel SHALL appear on outputs exactly one cycle later with data_valid_out=1; data_out_n = mem_rd_data_n if interior, else 0.
REQ-025 STREAM, stall=1: no issue, counters hold, mem_rd_en=0; pixel issued the previous cycle still emerges (no output backpressure).
REQ-026 Issue of (OUT_H-1,OUT_W-1) -> DRAIN; DRAIN emits that last pixel, then -> DONE.
REQ-027 DONE: done=1 for one cycle, data_valid_out=0, -> IDLE.
REQ-028 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-029 data_valid_out SHALL be high for exactly OUT_W*OUT_H cycles per frame; mem_rd_en for exactly IMG_WIDTH*IMG_HEIGHT.
REQ-030 PAD=0: no border pixels; every issue is a memory read.
REQ-031 data_out_n SHALL hold last value when data_valid_out=0.

Reset
REQ-032 resetn=0 SHALL immediately force IDLE, counters 0, mem_rd_en=0, mem_addr=0, data_out_0/1/2=0, data_valid_out=0, busy=0, done=0.
REQ-033 Reset mid-frame SHALL abort the frame with no done pulse; next start begins a fresh frame at address 0.

Verification (IMG_WIDTH=3, IMG_HEIGHT=2, PAD=1 unless stated; memory returns data_n = 100*n+addr)
REQ-034 start at edge k, stall=0 -> first data_valid_out at edge k+2 with data 0; 20 consecutive valid cycles; done at k+22; busy k+1..k+22.
REQ-035 Same run -> mem_addr 0..5 each read once; interior output (row1,col1) = {0,100,200}, (row2,col3) = {5,105,205}; all 14 border outputs zero.
REQ-036 stall=1 for 3 cycles mid-row -> exactly 3-cycle gap in data_valid_out after the in-flight pixel; pixel sequence and count unchanged.
REQ-037 PAD=0 -> 6 valid pixels, each a memory read, done 8 edges after start.
REQ-038 resetn low 2 cycles mid-frame -> all outputs 0 immediately, no done; new start yields full 20-pixel frame from address 0.
REQ-039 start pulsed during STREAM and during DONE -> ignored; exactly one frame and one done.
